// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared glyph geometry, bitmap type and blitter state encoding
package glyph_pkg;

  localparam int GLYPH_W = 25;
  localparam int GLYPH_H = 25;
  localparam int CTR_W   = 5;

  // Row index first (row 0 = top); within a row index 24 is the leftmost pixel.
  typedef logic [GLYPH_H-1:0][0:GLYPH_W-1] glyph_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } blit_state_e;

endpackage

// File: rtl/glyph_raster_ctr.sv
// rtl/glyph_raster_ctr.sv - row-major row/col scan counter over one glyph cell
module glyph_raster_ctr
  import glyph_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [CTR_W-1:0] o_row_nxt,
  output logic [CTR_W-1:0] o_col_nxt,
  output logic             o_last
);

  logic [CTR_W-1:0] r_row;
  logic [CTR_W-1:0] r_col;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == CTR_W'(GLYPH_W - 1));
  assign o_col_nxt  = w_col_wrap ? '0 : r_col + 1'b1;
  assign o_row_nxt  = w_col_wrap ? r_row + 1'b1 : r_row;
  assign o_last     = w_col_wrap && (r_row == CTR_W'(GLYPH_H - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      r_row <= o_row_nxt;
      r_col <= o_col_nxt;
    end
  end

endmodule

// File: rtl/glyph_blitter.sv
// rtl/glyph_blitter.sv - rasterises a 25x25 glyph into the frame buffer; GLYPH_TRANSPARENT_EN skips bg pixels
module glyph_blitter
  import glyph_pkg::*;
#(
  parameter int FB_W    = 640,
  parameter int FB_H    = 480,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  glyph_t             glyph,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               busy,
  output logic               done,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [X_W-1:0]     wr_x,
  output logic [Y_W-1:0]     wr_y,
  output logic [COLOR_W-1:0] wr_color
);

  blit_state_e        r_state;
  blit_state_e        w_state_nxt;
  glyph_t             r_glyph;
  logic [X_W-1:0]     r_ox;
  logic [Y_W-1:0]     r_oy;
  logic [COLOR_W-1:0] r_fg;
  logic               r_wr_valid;
  logic [X_W-1:0]     r_wr_x;
  logic [Y_W-1:0]     r_wr_y;
  logic [COLOR_W-1:0] r_wr_color;

  logic               w_start_acc;
  logic               w_resolve;
  logic               w_last;
  logic               w_load;
  logic               w_finish;
  logic [CTR_W-1:0]   w_row_nxt;
  logic [CTR_W-1:0]   w_col_nxt;
  logic [CTR_W-1:0]   w_ld_row;
  logic [CTR_W-1:0]   w_ld_col;
  glyph_t             w_src_glyph;
  logic [X_W-1:0]     w_src_ox;
  logic [Y_W-1:0]     w_src_oy;
  logic [COLOR_W-1:0] w_src_fg;
  logic               w_bit;
  logic [X_W:0]       w_x;
  logic [Y_W:0]       w_y;
  logic               w_in_fb;
  logic               w_pix_ok;
  logic [COLOR_W-1:0] w_pix_color;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_resolve   = (r_state == DRAW) && (!r_wr_valid || wr_ready);
  assign w_load      = w_start_acc || (w_resolve && !w_last);
  assign w_finish    = w_resolve && w_last;

  glyph_raster_ctr u_ctr (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_start_acc),
    .i_advance (w_resolve && !w_last),
    .o_row_nxt (w_row_nxt),
    .o_col_nxt (w_col_nxt),
    .o_last    (w_last)
  );

  // Pixel (0,0) is built straight from the inputs so it is on the port the cycle after start.
  assign w_ld_row    = w_start_acc ? '0 : w_row_nxt;
  assign w_ld_col    = w_start_acc ? '0 : w_col_nxt;
  assign w_src_glyph = w_start_acc ? glyph    : r_glyph;
  assign w_src_ox    = w_start_acc ? origin_x : r_ox;
  assign w_src_oy    = w_start_acc ? origin_y : r_oy;
  assign w_src_fg    = w_start_acc ? fg_color : r_fg;

  assign w_bit   = w_src_glyph[w_ld_row][CTR_W'(GLYPH_W - 1) - w_ld_col];
  assign w_x     = {1'b0, w_src_ox} + (X_W + 1)'(w_ld_col);
  assign w_y     = {1'b0, w_src_oy} + (Y_W + 1)'(w_ld_row);
  assign w_in_fb = (w_x < (X_W + 1)'(FB_W)) && (w_y < (Y_W + 1)'(FB_H));

`ifdef GLYPH_TRANSPARENT_EN
  logic w_unused_bg;
  assign w_unused_bg = ^bg_color;
  assign w_pix_ok    = w_in_fb && !w_bit;
  assign w_pix_color = w_src_fg;
`else
  logic [COLOR_W-1:0] r_bg;
  logic [COLOR_W-1:0] w_src_bg;
  assign w_src_bg    = w_start_acc ? bg_color : r_bg;
  assign w_pix_ok    = w_in_fb;
  assign w_pix_color = w_bit ? w_src_bg : w_src_fg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bg <= '0;
    end else if (w_start_acc) begin
      r_bg <= bg_color;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glyph <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_fg    <= '0;
    end else if (w_start_acc) begin
      r_glyph <= glyph;
      r_ox    <= origin_x;
      r_oy    <= origin_y;
      r_fg    <= fg_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = DRAW;
      DRAW:    if (w_finish) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A stalled write keeps its registers untouched, so x/y/colour hold until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_valid <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= '0;
    end else if (w_load) begin
      r_wr_valid <= w_pix_ok;
      r_wr_x     <= w_x[X_W-1:0];
      r_wr_y     <= w_y[Y_W-1:0];
      r_wr_color <= w_pix_color;
    end else if (w_finish) begin
      r_wr_valid <= 1'b0;
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign wr_valid = r_wr_valid;
  assign wr_x     = r_wr_x;
  assign wr_y     = r_wr_y;
  assign wr_color = r_wr_color;

endmodule

// File: tb/tb_glyph_blitter.sv
// tb/tb_glyph_blitter.sv - table-driven bench for glyph_blitter (honours GLYPH_TRANSPARENT_EN)
module tb_glyph_blitter;
  import glyph_pkg::*;

`ifdef GLYPH_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif
  localparam logic [11:0] FG = 12'hF00;
  localparam logic [11:0] BG = 12'h00F;

  logic        clk = 1'b0;
  logic        reset, start, wr_ready;
  logic [9:0]  origin_x;
  logic [8:0]  origin_y;
  glyph_t      glyph, g_ref;
  logic [11:0] fg_color, bg_color;
  logic        busy, done, wr_valid;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_color;

  glyph_blitter dut (
    .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .glyph(glyph), .fg_color(fg_color), .bg_color(bg_color), .busy(busy), .done(done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ox, oy, mode, poke, n_wr, last_x, last_y, done_cyc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int res_n, res_bad, res_hold, res_clip, res_vdone, res_done, res_bfall;
  int res_lx, res_ly, res_fx, res_fy;
  int qx[$], qy[$], qc[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int find_color(input int x, input int y);
    for (int i = 0; i < qx.size(); i++)
      if (qx[i] == x && qy[i] == y) return qc[i];
    return -1;
  endfunction

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_draw(input int ox, input int oy, input int mode, input int poke);
    int ex[$], ey[$], ec[$];
    int k;
    bit rdy, prev_stall;
    int px, py, pc;
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 25; c++) begin
        bit b;
        b = g_ref[r][24-c];
        if (ox + c < 640 && oy + r < 480 && !(TRANSP && b)) begin
          ex.push_back(ox + c); ey.push_back(oy + r); ec.push_back(b ? int'(BG) : int'(FG));
        end
      end
    qx.delete(); qy.delete(); qc.delete();
    res_n = 0; res_bad = 0; res_hold = 0; res_clip = 0; res_vdone = 0;
    res_done = -1; res_bfall = -1; res_lx = -1; res_ly = -1; res_fx = -1; res_fy = -1;
    px = 0; py = 0; pc = 0; prev_stall = 0;
    @(negedge clk);
    origin_x = 10'(ox); origin_y = 9'(oy); fg_color = FG; bg_color = BG;
    glyph = g_ref; start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    k = 1;
    while (k < 3000) begin
      if (poke != 0 && k == 100) begin
        start = 1'b1; origin_x = '0; origin_y = '0; glyph = '0;
        fg_color = 12'h0F0; bg_color = 12'h0F0;
      end else begin
        start = 1'b0;
      end
      if (done && res_done < 0) res_done = k;
      if (done && wr_valid) res_vdone++;
      if (!busy) begin
        res_bfall = k;
        break;
      end
      if (prev_stall && (!wr_valid || wr_x != px || wr_y != py || wr_color != pc)) res_hold++;
      rdy = (mode == 0) ? 1'b1 : ((k - 1) % 3 == 0);
      wr_ready = rdy;
      if (wr_valid && rdy) begin
        if (res_n < ex.size()) begin
          if (wr_x != ex[res_n] || wr_y != ey[res_n] || wr_color != ec[res_n]) res_bad++;
        end else begin
          res_bad++;
        end
        if (wr_x >= 640 || wr_y >= 480) res_clip++;
        if (res_n == 0) begin res_fx = wr_x; res_fy = wr_y; end
        res_lx = wr_x; res_ly = wr_y;
        qx.push_back(wr_x); qy.push_back(wr_y); qc.push_back(wr_color);
        res_n++;
      end
      prev_stall = wr_valid && !rdy;
      px = wr_x; py = wr_y; pc = wr_color;
      k++;
      @(negedge clk);
    end
    start = 1'b0; glyph = g_ref; fg_color = FG; bg_color = BG; wr_ready = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    int cnt, dn, k;
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 25; c++)
        g_ref[r][24-c] = !((c == 1 || c == 5 || c == 7) && r >= 3 && r <= 21);

    vecs[0] = '{100, 50, 0, 0, TRANSP ? 57 : 625, TRANSP ? 107 : 124, TRANSP ? 71 : 74, 626};
    vecs[1] = '{100, 50, 1, 0, TRANSP ? 57 : 625, TRANSP ? 107 : 124, TRANSP ? 71 : 74, -1};
    vecs[2] = '{630, 470, 0, 0, TRANSP ? 21 : 100, TRANSP ? 637 : 639, 479, 626};
    vecs[3] = '{615, 455, 0, 0, TRANSP ? 57 : 625, TRANSP ? 622 : 639, TRANSP ? 476 : 479, 626};
    vecs[4] = '{616, 456, 0, 0, TRANSP ? 57 : 576, TRANSP ? 623 : 639, TRANSP ? 477 : 479, 626};
    vecs[5] = '{0, 0, 1, 0, TRANSP ? 57 : 625, TRANSP ? 7 : 24, TRANSP ? 21 : 24, -1};
    vecs[6] = '{100, 50, 0, 1, TRANSP ? 57 : 625, TRANSP ? 107 : 124, TRANSP ? 71 : 74, 626};

    reset = 1'b1; start = 1'b0; wr_ready = 1'b1; glyph = g_ref;
    origin_x = '0; origin_y = '0; fg_color = FG; bg_color = BG;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_wr_color", wr_color, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_draw(vecs[i].ox, vecs[i].oy, vecs[i].mode, vecs[i].poke);
      check($sformatf("v%0d_n_writes", i), res_n, vecs[i].n_wr);
      check($sformatf("v%0d_stream_errs", i), res_bad, 0);
      check($sformatf("v%0d_last_x", i), res_lx, vecs[i].last_x);
      check($sformatf("v%0d_last_y", i), res_ly, vecs[i].last_y);
      check($sformatf("v%0d_stall_hold_errs", i), res_hold, 0);
      check($sformatf("v%0d_offscreen_writes", i), res_clip, 0);
      check($sformatf("v%0d_valid_in_done", i), res_vdone, 0);
      if (vecs[i].done_cyc > 0) begin
        check($sformatf("v%0d_done_cycle", i), res_done, vecs[i].done_cyc);
        check($sformatf("v%0d_busy_fall", i), res_bfall, vecs[i].done_cyc + 1);
      end else begin
        check($sformatf("v%0d_done_seen", i), (res_done > 0 && res_bfall == res_done + 1), 1);
      end
      if (i == 0) begin
        check("px_101_53", find_color(101, 53), int'(FG));
        check("px_100_53", find_color(100, 53), TRANSP ? -1 : int'(BG));
      end
    end

    // Reset on the 200th accepted write must abort without a done pulse.
    @(negedge clk);
    origin_x = 10'd100; origin_y = 9'd50; start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; k = 0;
    while (k < 1000) begin
      if (wr_valid) cnt++;
      if (cnt == 200) break;
      k++;
      @(negedge clk);
    end
    check("abort_at_200th", cnt, 200);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wr_valid", wr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort_no_done", dn, 0);
    run_draw(0, 0, 0, 0);
    check("redraw_first_x", res_fx, TRANSP ? 1 : 0);
    check("redraw_first_y", res_fy, TRANSP ? 3 : 0);
    check("redraw_n_writes", res_n, TRANSP ? 57 : 625);
    check("redraw_stream_errs", res_bad, 0);
    check("redraw_done_cycle", res_done, 626);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
